register_skid: RTL and testbench

//   Full-throughput valid/ready pipeline register (2-entry skid buffer): the

---
 rtl/register_skid.sv | 120 ++++++++++++
 tb/tb_register_skid.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/register_skid.sv
// register_skid: two-entry valid/ready skid buffer.
// The outputs toward both neighbours come straight from flops. m_valid and
// m_data drive the consumer. s_ready drives the producer. No combinational
// path runs from m_ready to s_ready, or from s_valid/s_data to m_valid/m_data.
// Optional build macro: REGISTER_SKID_STATS_EN adds a 16-bit saturating
// stall counter port (stall_cnt). This port is absent when the macro is
// undefined.
module register_skid #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data
`ifdef REGISTER_SKID_STATS_EN
  ,
  output logic [15:0]      stall_cnt
`endif
);

  // EMPTY: nothing held. BUSY: main register holds one beat.
  // FULL: both the main and skid registers hold a beat.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;

  logic s_in;
  logic m_out;

  // Handshake outputs are decoded only from the state flop.
  assign m_valid = (state_q != EMPTY);
  assign s_ready = (state_q != FULL);
  assign m_data  = main_q;

  assign s_in  = s_valid & s_ready;
  assign m_out = m_valid & m_ready;

  // Next-state and storage steering for the skid buffer.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (s_in) begin
          state_d = BUSY;
          main_d  = s_data;
        end
      end
      BUSY: begin
        if (s_in && m_out) begin
          main_d = s_data;
        end else if (s_in) begin
          // The consumer stalled: park the new beat in skid and keep main.
          state_d = FULL;
          skid_d  = s_data;
        end else if (m_out) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // s_ready is low here, so only the drain side can move.
        if (m_out) begin
          state_d = BUSY;
          main_d  = skid_q;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  // State and payload registers. Reset discards any held beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

`ifdef REGISTER_SKID_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Count cycles in which a beat is offered but refused. The count saturates.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (m_valid && !m_ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_register_skid.sv
// Directed and random bench for register_skid with an 8-bit payload.
// Inputs change 1 time unit after posedge. Outputs are sampled at the same
// point, so each sample shows the result of the edge just taken.
module tb_register_skid;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         s_valid;
  logic         s_ready;
  logic [W-1:0] s_data;
  logic         m_valid;
  logic         m_ready;
  logic [W-1:0] m_data;
`ifdef REGISTER_SKID_STATS_EN
  logic [15:0]  stall_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  register_skid #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data)
`ifdef REGISTER_SKID_STATS_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks the three DUT outputs and prints one line for the step.
  task automatic expect_out(input string tag, input logic v, input logic r, input logic [W-1:0] d);
    check({tag, ".m_valid"}, 32'(m_valid), 32'(v));
    check({tag, ".s_ready"}, 32'(s_ready), 32'(r));
    if (v || tag.substr(0, 2) == "rst") check({tag, ".m_data"}, 32'(m_data), 32'(d));
    $display("%s: m_valid=%0b s_ready=%0b m_data=%02h", tag, m_valid, s_ready, m_data);
  endtask

  logic [W-1:0] q[$];
  logic         hold_pending;
  logic [W-1:0] hold_data;

  initial begin
    rst = 1'b1; s_valid = 1'b1; s_data = 8'h55; m_ready = 1'b0;

    // 1: reset holds everything empty, even with s_valid high.
    tick(); expect_out("rst1", 1'b0, 1'b1, 8'h00);
    tick(); expect_out("rst2", 1'b0, 1'b1, 8'h00);

    // 2: back-to-back streaming with m_ready held high.
    rst = 1'b0; m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      s_valid = 1'b1; s_data = 8'(i);
      tick(); expect_out($sformatf("stream%0d", i), 1'b1, 1'b1, 8'(i));
    end
    s_valid = 1'b0;
    tick(); expect_out("stream_drain", 1'b0, 1'b1, 8'h00);

    // 3: backpressure fills skid, then drain in order.
    m_ready = 1'b0;
    s_valid = 1'b1; s_data = 8'h0A;
    tick(); expect_out("bp_A", 1'b1, 1'b1, 8'h0A);
    s_data = 8'h0B;
    tick(); expect_out("bp_B", 1'b1, 1'b0, 8'h0A);
    s_data = 8'h0C;
    tick(); expect_out("bp_C_held", 1'b1, 1'b0, 8'h0A);
    m_ready = 1'b1;
    tick(); expect_out("drain_B", 1'b1, 1'b1, 8'h0B);
    tick(); expect_out("drain_C", 1'b1, 1'b1, 8'h0C);
    s_valid = 1'b0;
    tick(); expect_out("drain_empty", 1'b0, 1'b1, 8'h00);

    // 4: random traffic against a queue scoreboard.
    q.delete();
    hold_pending = 1'b0;
    hold_data = '0;
    for (int c = 0; c < 2000; c++) begin
      s_valid = 1'($urandom);
      s_data  = 8'($urandom);
      m_ready = 1'($urandom);
      if (hold_pending) begin
        check("rnd_stable_valid", 32'(m_valid), 32'(1));
        check("rnd_stable_data", 32'(m_data), 32'(hold_data));
      end
      check("rnd_m_valid", 32'(m_valid), 32'(q.size() != 0));
      check("rnd_s_ready", 32'(s_ready), 32'(q.size() < 2));
      if (m_valid && m_ready && q.size() != 0) begin
        check("rnd_order", 32'(m_data), 32'(q[0]));
        void'(q.pop_front());
      end
      if (s_valid && s_ready) q.push_back(s_data);
      hold_pending = m_valid && !m_ready;
      hold_data = m_data;
      tick();
    end
    $display("random: %0d beats left in flight", q.size());
    s_valid = 1'b0; m_ready = 1'b1;
    tick(); tick();
    expect_out("rnd_flush", 1'b0, 1'b1, 8'h00);

    // 5: reset while FULL discards both held beats.
    m_ready = 1'b0; s_valid = 1'b1; s_data = 8'h01;
    tick(); s_data = 8'h02;
    tick(); expect_out("full_pre_rst", 1'b1, 1'b0, 8'h01);
    rst = 1'b1; s_data = 8'h09;
    tick(); expect_out("rst_full", 1'b0, 1'b1, 8'h00);
    rst = 1'b0; m_ready = 1'b1; s_data = 8'h05;
    tick(); expect_out("post_rst_5", 1'b1, 1'b1, 8'h05);
    s_valid = 1'b0;
    tick(); expect_out("post_rst_alone", 1'b0, 1'b1, 8'h00);

`ifdef REGISTER_SKID_STATS_EN
    // 6: the stall counter counts refused cycles, then saturates.
    rst = 1'b1; tick(); rst = 1'b0;
    check("stall_rst0", 32'(stall_cnt), 32'h0);
    m_ready = 1'b0; s_valid = 1'b1; s_data = 8'h77;
    tick(); s_valid = 1'b0;
    check("stall_start", 32'(stall_cnt), 32'h0);
    for (int i = 0; i < 100; i++) tick();
    check("stall_100", 32'(stall_cnt), 32'd100);
    for (int i = 0; i < 66000; i++) tick();
    check("stall_sat", 32'(stall_cnt), 32'hFFFF);
    $display("stall_cnt after saturation run: %04h", stall_cnt);
    rst = 1'b1; tick(); rst = 1'b0;
    check("stall_rst", 32'(stall_cnt), 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
